// File: rtl/display_stream_dispatcher_pkg.sv
// Shared types and constants for the display stream dispatcher.
// Covers the parser state encoding, the header field offsets, channel ids and error bit indices.
package display_stream_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_PAD     = 2'd2,
        ST_DRAIN   = 2'd3
    } state_e;

    localparam int TYPE_LSB = 0;
    localparam int LEN_LSB  = 16;

    localparam int CH_IMAGE = 1;
    localparam int CH_BBOX  = 2;
    localparam int CH_LOGO  = 3;

    localparam int ERR_W       = 3;
    localparam int ERR_TYPE    = 0;
    localparam int ERR_EARLY   = 1;
    localparam int ERR_MISSING = 2;

endpackage

// File: rtl/display_stream_dispatcher_skid.sv
// Two-entry register slice carrying data, last and destination channel; 1 cycle latency.
// in_rdy depends only on occupancy, so there is no combinational path from out_rdy to in_rdy.
module display_stream_skid #(
    parameter int DW  = 64,
    parameter int CHW = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_vld,
    input  logic           in_last,
    input  logic [DW-1:0]  in_dat,
    input  logic [CHW-1:0] in_ch,
    output logic           in_rdy,
    input  logic [CHW-1:0] chk_ch,
    output logic           other_ch,
    output logic           out_vld,
    output logic           out_last,
    output logic [DW-1:0]  out_dat,
    output logic [CHW-1:0] out_ch,
    input  logic           out_rdy
);
    logic [1:0]     cnt_q, cnt_d;
    logic [DW-1:0]  dat0_q, dat0_d, dat1_q, dat1_d;
    logic           last0_q, last0_d, last1_q, last1_d;
    logic [CHW-1:0] ch0_q, ch0_d, ch1_q, ch1_d;
    logic           push, pop;

    assign in_rdy   = (cnt_q != 2'd2);
    assign out_vld  = (cnt_q != 2'd0);
    assign out_last = last0_q;
    assign out_dat  = dat0_q;
    assign out_ch   = ch0_q;
    assign push     = in_vld & in_rdy;
    assign pop      = out_vld & out_rdy;
    // Lets the parser hold off a new channel until older channels' words have left.
    assign other_ch = ((cnt_q != 2'd0) && (ch0_q != chk_ch)) ||
                      ((cnt_q == 2'd2) && (ch1_q != chk_ch));

    always_comb begin
        cnt_d   = cnt_q;
        dat0_d  = dat0_q;
        dat1_d  = dat1_q;
        last0_d = last0_q;
        last1_d = last1_q;
        ch0_d   = ch0_q;
        ch1_d   = ch1_q;
        case ({push, pop})
            2'b10: begin
                if (cnt_q == 2'd0) begin
                    dat0_d  = in_dat;
                    last0_d = in_last;
                    ch0_d   = in_ch;
                end else begin
                    dat1_d  = in_dat;
                    last1_d = in_last;
                    ch1_d   = in_ch;
                end
                cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
                dat0_d  = dat1_q;
                last0_d = last1_q;
                ch0_d   = ch1_q;
                cnt_d   = cnt_q - 2'd1;
            end
            2'b11: begin
                dat0_d  = in_dat;
                last0_d = in_last;
                ch0_d   = in_ch;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= 2'd0;
            dat0_q  <= '0;
            dat1_q  <= '0;
            last0_q <= 1'b0;
            last1_q <= 1'b0;
            ch0_q   <= '0;
            ch1_q   <= '0;
        end else begin
            cnt_q   <= cnt_d;
            dat0_q  <= dat0_d;
            dat1_q  <= dat1_d;
            last0_q <= last0_d;
            last1_q <= last1_d;
            ch0_q   <= ch0_d;
            ch1_q   <= ch1_d;
        end
    end

endmodule

// File: rtl/display_stream_dispatcher.sv
// Parses a header word, routes its payload to one of NUM_CH channels and strips alignment padding.
// Latency 1 cycle to out_valid; in_ready drops when the skid is full or still holds another channel.
module display_stream_dispatcher
    import display_stream_pkg::*;
#(
    parameter int DATA_WIDTH  = 64,
    parameter int NUM_CH      = 4,
    parameter int TYPE_WIDTH  = 3,
    parameter int LEN_WIDTH   = 20,
    parameter int ALIGN_WORDS = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic                  in_last,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic [NUM_CH-1:0]     out_valid,
    output logic [NUM_CH-1:0]     out_last,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic [NUM_CH-1:0]     out_ready,
    output logic [ERR_W-1:0]      err_pulse,
    output logic                  pkt_done
);
    localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [LEN_WIDTH-1:0] ALIGN_MASK = LEN_WIDTH'(ALIGN_WORDS - 1);

    state_e               state_q, state_d;
    logic [CHW-1:0]       ch_q, ch_d;
    logic [LEN_WIDTH-1:0] len_q, len_d, pad_q, pad_d, cnt_q, cnt_d;
    logic [ERR_W-1:0]     err_q, err_d;
    logic                 done_q, done_d, run_q;

    logic [TYPE_WIDTH-1:0] hdr_type;
    logic [LEN_WIDTH-1:0]  hdr_len, hdr_pad;
    logic                  hdr_bad, accept, payload_end, pad_end;
    logic                  fwd_vld, fwd_last, sk_in_rdy, sk_other;
    logic                  sk_vld, sk_last, sk_out_rdy;
    logic [DATA_WIDTH-1:0] sk_dat;
    logic [CHW-1:0]        sk_ch;

    assign hdr_type    = in_data[TYPE_LSB +: TYPE_WIDTH];
    assign hdr_len     = in_data[LEN_LSB +: LEN_WIDTH];
    // -(len+1) == ~len, so the pad to the next alignment boundary is just the low bits of ~len.
    assign hdr_pad     = ~hdr_len & ALIGN_MASK;
    assign hdr_bad     = 32'(hdr_type) >= NUM_CH;
    assign payload_end = (cnt_q == len_q - LEN_WIDTH'(1));
    assign pad_end     = (cnt_q == pad_q - LEN_WIDTH'(1));
    assign accept      = in_valid & in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ch_q    <= '0;
            len_q   <= '0;
            pad_q   <= '0;
            cnt_q   <= '0;
            err_q   <= '0;
            done_q  <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            len_q   <= len_d;
            pad_q   <= pad_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            done_q  <= done_d;
            run_q   <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        len_d   = len_q;
        pad_d   = pad_q;
        cnt_d   = cnt_q;
        err_d   = '0;
        done_d  = 1'b0;
        if (accept) begin
            case (state_q)
                ST_IDLE: begin
                    ch_d  = hdr_type[CHW-1:0];
                    len_d = hdr_len;
                    pad_d = hdr_pad;
                    cnt_d = '0;
                    if (hdr_bad) begin
                        err_d[ERR_TYPE] = 1'b1;
                        state_d = in_last ? ST_IDLE : ST_DRAIN;
                    end else if (hdr_len == '0 && hdr_pad == '0) begin
                        done_d = in_last;
                        err_d[ERR_MISSING] = ~in_last;
                        state_d = in_last ? ST_IDLE : ST_DRAIN;
                    end else if (in_last) begin
                        err_d[ERR_EARLY] = 1'b1;
                    end else begin
                        state_d = (hdr_len != '0) ? ST_PAYLOAD : ST_PAD;
                    end
                end
                ST_PAYLOAD: begin
                    cnt_d = cnt_q + LEN_WIDTH'(1);
                    if (payload_end && pad_q == '0) begin
                        done_d = in_last;
                        err_d[ERR_MISSING] = ~in_last;
                        state_d = in_last ? ST_IDLE : ST_DRAIN;
                    end else if (in_last) begin
                        err_d[ERR_EARLY] = 1'b1;
                        state_d = ST_IDLE;
                    end else if (payload_end) begin
                        cnt_d   = '0;
                        state_d = ST_PAD;
                    end
                end
                ST_PAD: begin
                    cnt_d = cnt_q + LEN_WIDTH'(1);
                    if (pad_end) begin
                        done_d = in_last;
                        err_d[ERR_MISSING] = ~in_last;
                        state_d = in_last ? ST_IDLE : ST_DRAIN;
                    end else if (in_last) begin
                        err_d[ERR_EARLY] = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                ST_DRAIN: begin
                    if (in_last) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready = run_q;
        if (state_q == ST_PAYLOAD) in_ready = run_q & sk_in_rdy & ~sk_other;
        fwd_vld  = in_valid & in_ready & (state_q == ST_PAYLOAD);
        fwd_last = payload_end | in_last;
    end

    display_stream_skid #(
        .DW  (DATA_WIDTH),
        .CHW (CHW)
    ) u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_vld   (fwd_vld),
        .in_last  (fwd_last),
        .in_dat   (in_data),
        .in_ch    (ch_q),
        .in_rdy   (sk_in_rdy),
        .chk_ch   (ch_q),
        .other_ch (sk_other),
        .out_vld  (sk_vld),
        .out_last (sk_last),
        .out_dat  (sk_dat),
        .out_ch   (sk_ch),
        .out_rdy  (sk_out_rdy)
    );

    always_comb begin
        out_valid = '0;
        out_last  = '0;
        if (sk_vld) begin
            out_valid[sk_ch] = 1'b1;
            out_last[sk_ch]  = sk_last;
        end
    end

    assign sk_out_rdy = out_ready[sk_ch];
    assign out_data   = sk_dat;
    assign err_pulse  = err_q;
    assign pkt_done   = done_q;

endmodule

// File: tb/tb_display_stream_dispatcher.sv
// Bench for display_stream_dispatcher: directed table, hand sequences and random packets
// checked against a packet-level model and an in-order output scoreboard.
module tb_display_stream_dispatcher;
    import display_stream_pkg::*;

    localparam int DW = 64, NCH = 4, TW = 3, LW = 20, AW = 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0, in_last = 1'b0;
    logic [DW-1:0]  in_data = '0;
    logic           in_ready;
    logic [NCH-1:0] out_valid, out_last, out_ready = '0;
    logic [DW-1:0]  out_data;
    logic [2:0]     err_pulse;
    logic           pkt_done;

    always #5 clk = ~clk;

    display_stream_dispatcher #(
        .DATA_WIDTH(DW), .NUM_CH(NCH), .TYPE_WIDTH(TW), .LEN_WIDTH(LW), .ALIGN_WORDS(AW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_last(in_last), .in_data(in_data),
        .in_ready(in_ready), .out_valid(out_valid), .out_last(out_last), .out_data(out_data),
        .out_ready(out_ready), .err_pulse(err_pulse), .pkt_done(pkt_done)
    );

    typedef struct { int ch; logic [DW-1:0] dat; logic last; } exp_t;
    typedef struct { int typ; int len; int p; int words; int e0; int e1; int e2; int done; } vec_t;

    exp_t expq[$];
    exp_t mon_e;
    int total = 0, bad = 0;
    int n_e0 = 0, n_e1 = 0, n_e2 = 0, n_done = 0, n_out = 0;
    int x_e0 = 0, x_e1 = 0, x_e2 = 0, x_done = 0;
    int ready_mode = 0;
    logic           pstall = 1'b0;
    logic [NCH-1:0] pv, pl, mask;
    logic [DW-1:0]  pd;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, act, req);
        end
    endtask

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0: out_ready = '1;
            1: out_ready = NCH'($urandom);
            2: out_ready = {2'b11, ~out_ready[1], 1'b1};
            default: out_ready = '0;
        endcase
    end

    // Output monitor: in-order scoreboard, hold stability, one-hot and pulse exclusivity.
    always @(negedge clk) begin
        if (!rst_n) begin
            pstall = 1'b0;
        end else begin
            n_e0 += int'(err_pulse[0]);
            n_e1 += int'(err_pulse[1]);
            n_e2 += int'(err_pulse[2]);
            n_done += int'(pkt_done);
            if (err_pulse != 3'b0 || pkt_done)
                check("pulse_excl", $countones({err_pulse, pkt_done}), 1);
            if (pstall) begin
                check("hold_vld", out_valid, pv);
                check("hold_dat", out_data, pd);
                check("hold_last", out_last, pl);
            end
            if (out_valid != '0) check("onehot", $countones(out_valid), 1);
            if ((out_valid & out_ready) != '0) begin
                n_out++;
                if (expq.size() == 0) begin
                    check("unexpected_out", out_valid, 0);
                end else begin
                    mon_e = expq.pop_front();
                    mask  = NCH'(1) << mon_e.ch;
                    check("out_ch", out_valid, mask);
                    check("out_dat", out_data, mon_e.dat);
                    check("out_last", out_last, mon_e.last ? mask : '0);
                end
            end
            pstall = (out_valid != '0) && ((out_valid & out_ready) == '0);
            pv = out_valid;
            pd = out_data;
            pl = out_last;
        end
    end

    task automatic put_word(input logic [DW-1:0] d, input logic last);
        int budget = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        while (!in_ready && budget < 500) begin
            @(posedge clk); #1;
            budget++;
        end
        if (!in_ready) check("in_ready_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Packet-level model: header, p words after it, in_last on word p (header is word 0).
    task automatic send_pkt(input int typ, input int len, input int p);
        logic [DW-1:0] w[$];
        logic [DW-1:0] hdr;
        int pad, tot, nf;
        hdr = {$urandom, $urandom};
        hdr[TYPE_LSB +: TW] = TW'(typ);
        hdr[LEN_LSB +: LW]  = LW'(len);
        w.push_back(hdr);
        for (int i = 1; i <= p; i++) w.push_back({$urandom, $urandom});
        pad = (AW - (1 + len) % AW) % AW;
        tot = len + pad;
        if (typ >= NCH) begin
            x_e0++;
        end else begin
            nf = (p < len) ? p : len;
            for (int i = 1; i <= nf; i++) expq.push_back('{typ, w[i], i == nf});
            if (p == tot) x_done++;
            else if (p < tot) x_e1++;
            else x_e2++;
        end
        for (int i = 0; i <= p; i++) put_word(w[i], i == p);
    endtask

    task automatic settle();
        int budget = 0;
        while (expq.size() != 0 && budget < 2000) begin
            @(posedge clk); #1;
            budget++;
        end
        if (expq.size() != 0) check("drain_timeout", expq.size(), 0);
        repeat (3) begin @(posedge clk); #1; end
    endtask

    vec_t tbl[12];

    initial begin
        int b0, b1, b2, bd, bo, typ, len, p, tot;
        logic [DW-1:0] hw;

        tbl[0]  = '{CH_IMAGE, 4, 5, 4, 0, 0, 0, 1};
        tbl[1]  = '{CH_BBOX,  3, 3, 3, 0, 0, 0, 1};
        tbl[2]  = '{5,        7, 3, 0, 1, 0, 0, 0};
        tbl[3]  = '{CH_IMAGE, 2, 3, 2, 0, 0, 0, 1};
        tbl[4]  = '{CH_IMAGE, 6, 2, 2, 0, 1, 0, 0};
        tbl[5]  = '{CH_LOGO,  2, 5, 2, 0, 0, 1, 0};
        tbl[6]  = '{0,        0, 1, 0, 0, 0, 0, 1};
        tbl[7]  = '{CH_BBOX,  1, 0, 0, 0, 1, 0, 0};
        tbl[8]  = '{CH_LOGO,  5, 5, 5, 0, 0, 0, 1};
        tbl[9]  = '{0,        1, 3, 1, 0, 0, 1, 0};
        tbl[10] = '{4,        0, 0, 0, 1, 0, 0, 0};
        tbl[11] = '{CH_IMAGE, 'hFFFFF, 2, 2, 0, 1, 0, 0};

        #2;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_out_data", out_data, 0);
        check("rst_err", err_pulse, 0);
        check("rst_done", pkt_done, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_in_ready", in_ready, 1);

        ready_mode = 0;
        foreach (tbl[i]) begin
            b0 = n_e0; b1 = n_e1; b2 = n_e2; bd = n_done; bo = n_out;
            send_pkt(tbl[i].typ, tbl[i].len, tbl[i].p);
            settle();
            check($sformatf("t%0d_words", i), n_out - bo, tbl[i].words);
            check($sformatf("t%0d_e0", i), n_e0 - b0, tbl[i].e0);
            check($sformatf("t%0d_e1", i), n_e1 - b1, tbl[i].e1);
            check($sformatf("t%0d_e2", i), n_e2 - b2, tbl[i].e2);
            check($sformatf("t%0d_done", i), n_done - bd, tbl[i].done);
        end

        // Back-to-back channel changes with ch1 ready toggling.
        ready_mode = 2;
        bd = n_done; bo = n_out;
        send_pkt(CH_IMAGE, 4, 5);
        send_pkt(CH_BBOX, 3, 3);
        send_pkt(CH_IMAGE, 2, 3);
        settle();
        check("b2b_done", n_done - bd, 3);
        check("b2b_words", n_out - bo, 9);

        // Reset while words are stalled in the skid buffer.
        ready_mode = 3;
        @(posedge clk); #1;
        hw = {$urandom, $urandom};
        hw[TYPE_LSB +: TW] = TW'(CH_IMAGE);
        hw[LEN_LSB +: LW]  = LW'(8);
        put_word(hw, 1'b0);
        put_word({$urandom, $urandom}, 1'b0);
        put_word({$urandom, $urandom}, 1'b0);
        check("pre_rst_valid", out_valid, 4'b0010);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_last", out_last, 0);
        check("mid_rst_in_ready", in_ready, 0);
        expq.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        ready_mode = 0;
        bd = n_done; bo = n_out;
        send_pkt(CH_LOGO, 3, 3);
        settle();
        check("post_rst_done", n_done - bd, 1);
        check("post_rst_words", n_out - bo, 3);

        // Random packets with random backpressure, issued back to back.
        ready_mode = 1;
        for (int k = 0; k < 40; k++) begin
            typ = $urandom_range(0, 7);
            len = $urandom_range(0, 7);
            tot = len + (AW - (1 + len) % AW) % AW;
            p   = ($urandom_range(0, 3) != 0) ? tot : $urandom_range(0, tot + 3);
            send_pkt(typ, len, p);
        end
        settle();

        check("tot_e0", n_e0, x_e0);
        check("tot_e1", n_e1, x_e1);
        check("tot_e2", n_e2, x_e2);
        check("tot_done", n_done, x_done);
        check("queue_empty", expq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
